fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have port CLK  in  1  system clock, rising-edge active.
REQ-002 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port pc  in  32  current PC from the PC register.
REQ-004 SHALL have port npc  in  32  PC+4 from the PC register.
REQ-005 SHALL have port ihit  in  1  instruction memory hit; iload valid this cycle.
REQ-006 SHALL have port iload  in  32  instruction word from instruction memory.
REQ-007 SHALL have port stall  in  1  hazard unit: ID cannot accept a new instruction.
REQ-008 SHALL have port flush  in  1  taken branch or jump; squash the fetched path.
REQ-009 SHALL have port halt  in  1  HALT decoded in ID.
REQ-010 SHALL have port imemREN  out  1  instruction read request.
REQ-011 SHALL have port imemaddr  out  32  instruction address.
REQ-012 SHALL have port pc_en  out  1  PC register load enable.
REQ-013 SHALL have port ifid_instr  out  32  IF/ID latched instruction.
REQ-014 SHALL have port ifid_npc  out  32  IF/ID latched PC+4.
REQ-015 SHALL have port ifid_valid  out  1  IF/ID holds a live instruction.
REQ-016 SHALL have port fetch_cnt  out  32  count of instructions delivered to IF/ID.

Function
REQ-017 SHALL implement states FETCH, HOLD, HALTED.
REQ-018 SHALL drive imemaddr = pc combinationally in every state.
REQ-019 SHALL assert imemREN only in FETCH.
REQ-020 FETCH, ihit=1, stall=0, flush=0: SHALL assert pc_en the same cycle; at the next edge, load ifid_instr=iload and ifid_npc=npc, set ifid_valid=1, increment fetch_cnt.
REQ-021 FETCH, ihit=1, stall=1, flush=0: SHALL assert pc_en; capture iload/npc into a one-entry hold buffer; go to HOLD; leave IF/ID unchanged.
REQ-022 FETCH, ihit=0, flush=0: SHALL hold pc_en=0; leave IF/ID unchanged.
REQ-023 HOLD, stall=1: SHALL keep imemREN=0, pc_en=0, and both buffers unchanged.
REQ-024 HOLD, stall=0: SHALL move the hold buffer into IF/ID with ifid_valid=1; increment fetch_cnt; return to FETCH. No fetch this cycle.
REQ-025 flush=1 in FETCH or HOLD: SHALL assert pc_en so the redirect target loads, regardless of ihit and stall.
REQ-026 flush=1 (cont.): next edge SHALL clear ifid_instr to 0 and ifid_valid to 0; discard the hold buffer and any concurrent iload; enter FETCH; leave fetch_cnt unchanged.
REQ-027 flush SHALL take priority over halt, stall and ihit.
REQ-028 halt=1 with flush=0 in FETCH or HOLD: SHALL enter HALTED at next edge; pc_en=0 that cycle; IF/ID unchanged.
REQ-029 In HALTED: SHALL hold imemREN=0, pc_en=0, ifid_valid=0; ignore all inputs until reset.
REQ-030 fetch_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-031 pc_en SHALL be a pure combinational function of state, ihit, stall, flush and halt; no register delay.

Reset
REQ-032 nRST low SHALL immediately set state=FETCH and clear the hold buffer.
REQ-033 nRST low SHALL immediately set ifid_instr=0, ifid_npc=0, ifid_valid=0, fetch_cnt=0.
REQ-034 Reset mid-HOLD or mid-HALTED SHALL discard all held data; first fetch after deassertion uses the pc present then.

Structure
REQ-035 word_t (32-bit) and the fetch_state_t enum SHALL live in cpu_types_pkg.
REQ-036 The IF/ID register (instr, npc, valid, with load and clear controls) SHALL be a sub-module ifid_reg; FSM, hold buffer and counter stay in fetch_ctrl.

Verification
REQ-037 Reset, then ihit=1 with iload=0x8C220004, npc=0x4, stall=0 -> pc_en=1 same cycle; next cycle ifid_instr=0x8C220004, ifid_npc=0x4, valid=1, fetch_cnt=1.
REQ-038 ihit=1 with iload=0x00431020 while stall=1 for 3 cycles -> HOLD, imemREN=0, IF/ID unchanged; on stall=0 -> ifid_instr=0x00431020 next cycle, FETCH resumes.
REQ-039 flush=1 concurrent with ihit=1 and stall=1 -> pc_en=1; next cycle ifid_valid=0, ifid_instr=0, fetch_cnt unchanged, state FETCH.
REQ-040 flush=1 while in HOLD -> hold buffer never reaches IF/ID; ifid_valid=0.
REQ-041 halt=1 -> HALTED; 10 cycles of ihit=1 -> imemREN=0, pc_en=0, valid=0; nRST pulse restores FETCH.
REQ-042 Force fetch_cnt=0xFFFFFFFF, deliver one instruction -> fetch_cnt=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and fetch controller state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, PC+4 and a live bit.
// clear squashes the slot (instr and valid only); clear wins over load.
module ifid_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  load,
    input  logic  clear,
    input  word_t instr_d,
    input  word_t npc_d,
    output word_t instr,
    output word_t npc,
    output logic  valid
);

    // Slot register with async reset, squash and load.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr <= '0;
            npc   <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            instr <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_d;
            npc   <= npc_d;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: FETCH/HOLD/HALTED FSM, one-entry hold
// buffer for words that arrive while ID is stalled, and a delivered-
// instruction counter. Redirects (flush) override everything else.
module fetch_ctrl
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  word_t pc,
    input  word_t npc,
    input  logic  ihit,
    input  word_t iload,
    input  logic  stall,
    input  logic  flush,
    input  logic  halt,
    output logic  imemREN,
    output word_t imemaddr,
    output logic  pc_en,
    output word_t ifid_instr,
    output word_t ifid_npc,
    output logic  ifid_valid,
    output word_t fetch_cnt
);

    fetch_state_t state, state_n;
    word_t        hold_instr, hold_npc;
    word_t        cnt_q;
    logic         ifid_valid_q;

    // Control decoded each cycle.
    logic  ld_ifid, clr_ifid, cap_hold, cnt_inc;
    word_t ifid_instr_d, ifid_npc_d;

    assign imemaddr  = pc;
    assign fetch_cnt = cnt_q;
    // Halted pipeline presents no live instruction, but the slot keeps its data.
    assign ifid_valid = ifid_valid_q && (state != HALTED);

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= FETCH;
        else       state <= state_n;
    end

    // Next state and per-cycle controls; priority flush > halt > stall/ihit.
    always_comb begin
        state_n      = state;
        imemREN      = 1'b0;
        pc_en        = 1'b0;
        ld_ifid      = 1'b0;
        clr_ifid     = 1'b0;
        cap_hold     = 1'b0;
        cnt_inc      = 1'b0;
        ifid_instr_d = iload;
        ifid_npc_d   = npc;
        case (state)
            FETCH: begin
                imemREN = 1'b1;
                if (flush) begin
                    pc_en    = 1'b1;
                    clr_ifid = 1'b1;
                end else if (halt) begin
                    state_n = HALTED;
                end else if (ihit && !stall) begin
                    pc_en   = 1'b1;
                    ld_ifid = 1'b1;
                    cnt_inc = 1'b1;
                end else if (ihit) begin
                    pc_en    = 1'b1;
                    cap_hold = 1'b1;
                    state_n  = HOLD;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_en    = 1'b1;
                    clr_ifid = 1'b1;
                    state_n  = FETCH;
                end else if (halt) begin
                    state_n = HALTED;
                end else if (!stall) begin
                    ld_ifid      = 1'b1;
                    cnt_inc      = 1'b1;
                    ifid_instr_d = hold_instr;
                    ifid_npc_d   = hold_npc;
                    state_n      = FETCH;
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    // Hold buffer: captures the word fetched while ID was stalled.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hold_instr <= '0;
            hold_npc   <= '0;
        end else if (cap_hold) begin
            hold_instr <= iload;
            hold_npc   <= npc;
        end
    end

    // Delivered-instruction counter; wraps naturally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        cnt_q <= '0;
        else if (cnt_inc) cnt_q <= cnt_q + 32'd1;
    end

    ifid_reg u_ifid (
        .CLK     (CLK),
        .nRST    (nRST),
        .load    (ld_ifid),
        .clear   (clr_ifid),
        .instr_d (ifid_instr_d),
        .npc_d   (ifid_npc_d),
        .instr   (ifid_instr),
        .npc     (ifid_npc),
        .valid   (ifid_valid_q)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a scoreboard of expected deliveries.
module tb_fetch_ctrl;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    word_t pc, npc, iload;
    logic  ihit, stall, flush, halt;
    logic  imemREN, pc_en, ifid_valid;
    word_t imemaddr, ifid_instr, ifid_npc, fetch_cnt;

    typedef struct packed {
        word_t instr;
        word_t npc;
        word_t cnt;
    } deliv_t;

    deliv_t exp_q[$];
    int total = 0;
    int bad   = 0;

    fetch_ctrl dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .pc         (pc),
        .npc        (npc),
        .ihit       (ihit),
        .iload      (iload),
        .stall      (stall),
        .flush      (flush),
        .halt       (halt),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .pc_en      (pc_en),
        .ifid_instr (ifid_instr),
        .ifid_npc   (ifid_npc),
        .ifid_valid (ifid_valid),
        .fetch_cnt  (fetch_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pop the oldest expected delivery and compare with IF/ID.
    task automatic pop_chk(input string tag);
        deliv_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_instr"}, ifid_instr, e.instr);
            chk({tag, "_npc"},   ifid_npc,   e.npc);
            chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd1);
            chk({tag, "_cnt"},   fetch_cnt,  e.cnt);
        end
    endtask

    task automatic drive(input word_t p, input word_t np, input logic h,
                         input word_t ld, input logic s, input logic f,
                         input logic hl);
        pc = p; npc = np; ihit = h; iload = ld; stall = s; flush = f; halt = hl;
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(32'h0, 32'h4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        // Reset state
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_npc",   ifid_npc,   32'h0);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_cnt",   fetch_cnt,  32'h0);
        chk("rst_ren",   {31'd0, imemREN}, 32'd1);
        nRST = 1'b1;
        tick();

        // Plain fetch
        drive(32'h0, 32'h4, 1'b1, 32'h8C220004, 1'b0, 1'b0, 1'b0);
        chk("f1_pcen", {31'd0, pc_en}, 32'd1);
        chk("f1_addr", imemaddr, 32'h0);
        exp_q.push_back('{32'h8C220004, 32'h4, 32'd1});
        tick();
        drive(32'h4, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        pop_chk("f1");
        chk("miss_pcen", {31'd0, pc_en}, 32'd0);
        chk("miss_addr", imemaddr, 32'h4);

        // Fetch under stall -> HOLD for 3 cycles
        drive(32'h4, 32'h8, 1'b1, 32'h00431020, 1'b1, 1'b0, 1'b0);
        chk("st_pcen", {31'd0, pc_en}, 32'd1);
        exp_q.push_back('{32'h00431020, 32'h8, 32'd2});
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(32'h8, 32'hC, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
            chk("hold_ren",   {31'd0, imemREN}, 32'd0);
            chk("hold_pcen",  {31'd0, pc_en},   32'd0);
            chk("hold_instr", ifid_instr, 32'h8C220004);
            chk("hold_cnt",   fetch_cnt,  32'd1);
            if (i < 2) tick();
        end
        drive(32'h8, 32'hC, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        chk("rel_pcen", {31'd0, pc_en},   32'd0);
        chk("rel_ren",  {31'd0, imemREN}, 32'd0);
        tick();
        drive(32'h8, 32'hC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        pop_chk("hold_out");
        chk("resume_ren", {31'd0, imemREN}, 32'd1);

        // Flush beats ihit, stall and halt
        drive(32'h8, 32'hC, 1'b1, 32'h11111111, 1'b1, 1'b1, 1'b1);
        chk("fl_pcen", {31'd0, pc_en}, 32'd1);
        tick();
        drive(32'h20, 32'h24, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("fl_valid", {31'd0, ifid_valid}, 32'd0);
        chk("fl_instr", ifid_instr, 32'h0);
        chk("fl_cnt",   fetch_cnt,  32'd2);
        chk("fl_ren",   {31'd0, imemREN}, 32'd1);

        // Flush while in HOLD drops the held word
        drive(32'h20, 32'h24, 1'b1, 32'h22222222, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'h24, 32'h28, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("flh_ren",  {31'd0, imemREN}, 32'd0);
        chk("flh_pcen", {31'd0, pc_en},   32'd1);
        tick();
        drive(32'h40, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("flh_valid", {31'd0, ifid_valid}, 32'd0);
        chk("flh_instr", ifid_instr, 32'h0);
        chk("flh_ren2",  {31'd0, imemREN}, 32'd1);
        tick();
        chk("flh_valid2", {31'd0, ifid_valid}, 32'd0);
        chk("flh_cnt",    fetch_cnt, 32'd2);

        // Counter wrap
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.cnt_q;
        chk("wrap_pre", fetch_cnt, 32'hFFFFFFFF);
        drive(32'h40, 32'h44, 1'b1, 32'h33333333, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{32'h33333333, 32'h44, 32'd0});
        tick();
        drive(32'h44, 32'h48, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        pop_chk("wrap");

        // Halt, then ignore fetch hits
        drive(32'h44, 32'h48, 1'b1, 32'h44444444, 1'b0, 1'b0, 1'b1);
        chk("halt_pcen", {31'd0, pc_en}, 32'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(32'h44, 32'h48, 1'b1, 32'h55555555, i[0], 1'b0, 1'b0);
            chk("hlt_ren",   {31'd0, imemREN},    32'd0);
            chk("hlt_pcen",  {31'd0, pc_en},      32'd0);
            chk("hlt_valid", {31'd0, ifid_valid}, 32'd0);
            chk("hlt_cnt",   fetch_cnt,  32'd0);
            tick();
        end
        chk("hlt_instr", ifid_instr, 32'h33333333);

        // Async reset mid-cycle restores FETCH
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_instr", ifid_instr, 32'h0);
        chk("arst_ren",   {31'd0, imemREN}, 32'd1);
        tick();
        nRST = 1'b1;
        drive(32'h80, 32'h84, 1'b1, 32'h66666666, 1'b0, 1'b0, 1'b0);
        chk("post_pcen", {31'd0, pc_en}, 32'd1);
        chk("post_addr", imemaddr, 32'h80);
        exp_q.push_back('{32'h66666666, 32'h84, 32'd1});
        tick();
        drive(32'h84, 32'h88, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        pop_chk("post");

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
